fetch_unit: RTL

- Instruction-fetch initiator that drives the word address into the instruction memory and receives the combinational instruction word back in the same cycle.
- Keeps the program counter and buffers fetched words in a small FIFO with their PCs.
- Hands words to decode over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and reloading the PC.

---
 rtl/fetch_unit.sv | 79 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the PC to a combinational instruction memory,
// buffers fetched words with their PCs in a small FIFO, and hands them to decode.
module fetch_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0,
    parameter int unsigned           PC_STEP  = 1,
    parameter int unsigned           DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  PC_Out,
    input  logic [INSTR_W-1:0] theInstruction,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [INSTR_W-1:0] r_instr_buf [DEPTH];
    logic [ADDR_W-1:0]  r_pc_buf    [DEPTH];

    logic w_pop;
    logic w_full;
    logic w_fetch;

    always_comb begin
        w_pop   = (r_count != '0) && instr_ready;
        w_full  = (r_count == CNT_W'(DEPTH));
        // A pop frees a slot this cycle, so a full FIFO can still accept a fetch.
        w_fetch = !branch_valid && (!w_full || w_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_instr_buf[i] <= '0;
                r_pc_buf[i]    <= '0;
            end
        end else if (branch_valid) begin
            r_pc     <= branch_target;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_fetch) begin
                r_instr_buf[r_wr_ptr] <= theInstruction;
                r_pc_buf[r_wr_ptr]    <= r_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                r_pc                  <= r_pc + ADDR_W'(PC_STEP);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_fetch) - CNT_W'(w_pop);
        end
    end

    always_comb begin
        PC_Out      = r_pc;
        instr_valid = (r_count != '0);
        instr_out   = r_instr_buf[r_rd_ptr];
        instr_pc    = r_pc_buf[r_rd_ptr];
    end

endmodule
